pe_result_drain: RTL and testbench
==================================

// Module: pe_result_drain
// PURPOSE
//  Read side of the PE accumulator path. Captures one row of N 32-bit PE
//  out_sum results per accepted cycle and buffers it in a DEPTH-row FIFO.
//  Serializes each row onto a 32-bit valid/ready output stream, column 0
//  first. out_ready is the axiout_ready that the PE array expects. out_last
//  marks the final word of each ROWS x N result tile.
// PARAMETERS
//  N      8  columns per row (32-bit words per row); >=2
//  DEPTH  4  rows buffered in the FIFO; power of 2, >=2
//  ROWS   8  rows per tile, used for out_last; >=1
// PORTS
//  clk        in   1      clock (single domain)
//  rst        in   1      asynchronous reset, active-high
//  row_valid  in   1      row_data holds a complete result row
//  row_ready  out  1      FIFO can accept a row (= !full)
//  row_data   in   32*N   packed row; column c at [c*32+:32]
//  out_data   out  32     current output word
//  out_valid  out  1      out_data/out_last valid
//  out_ready  in   1      downstream accepts word (axiout_ready)
//  out_last   out  1      last word of the tile
//  overflow   out  1      sticky: a row was offered while FIFO full
//  busy       out  1      data buffered or a row is mid-serialization
// BEHAVIOUR
//  Reset (async assert, sync release)
//   - Clears FIFO pointers, count, col_idx, row_cnt and overflow; FSM -> IDLE.
//   - Outputs: out_valid=0, out_last=0, busy=0, overflow=0, out_data=0, row_ready=1.
//   - Reset mid-transfer discards all buffered rows and any partly sent row.
//     out_valid drops immediately on reset assertion.
//  Push
//   - Row written at posedge when row_valid && row_ready.
//   - row_ready = (count != DEPTH), computed from the registered count.
//   - No same-cycle passthrough: a pop in the same cycle does not free a slot
//     for a push that cycle.
//   - row_valid && !row_ready: row dropped and overflow set to 1. overflow stays
//     1 until rst; FIFO contents are unchanged.
//  Pop / serialization
//   - Head row is visible on the output from the cycle after its push edge.
//     Latency: row_valid accepted at edge k -> out_valid=1 from edge k onward
//     (first word visible in cycle k+1).
//   - out_data = head[col_idx*32+:32]; out_valid = (count != 0).
//   - While out_valid && !out_ready: out_data, out_last and out_valid stay stable.
//   - Handshake (out_valid && out_ready) advances col_idx.
//     At col_idx == N-1: col_idx wraps to 0, the head row is popped, and
//     row_cnt increments. row_cnt wraps to 0 after ROWS-1.
//   - out_last = out_valid && (col_idx == N-1) && (row_cnt == ROWS-1).
//   - Peak throughput 1 word/clk; sustained input rate 1 row per N clk.
//   - Simultaneous push and pop: count unchanged, pointers both advance.
//   - Pointers wrap modulo DEPTH.
//  FSM
//   - IDLE: count == 0. Go to STREAM when a row is pushed.
//   - STREAM: serializing. Go to IDLE on the final-column pop when count == 1
//     and there is no push in the same cycle. Otherwise stay (back-to-back rows
//     with no bubble).
//   - busy = (state == STREAM).
//  Arithmetic
//   - count is $clog2(DEPTH)+1 bits.
//   - col_idx is $clog2(N) bits; row_cnt is $clog2(ROWS) bits (min 1).
//   - Words pass through unmodified; no sign or width change.
// TESTING
//  T1 single row: N=8, push row c_i=32'h100+i, out_ready=1
//     -> 8 words 0x100..0x107 on consecutive clocks.
//     -> out_valid rises the cycle after the push; busy returns to 0 after the last word.
//  T2 backpressure: toggle out_ready 1,0,0,1,...
//     -> out_data is held during ready=0.
//     -> No word is lost or duplicated; order is 0x100..0x107.
//  T3 full/overflow: out_ready=0; push 5 rows (DEPTH=4)
//     -> row_ready=0 after the 4th push; overflow=1 after the 5th.
//     -> With out_ready=1: exactly 32 words drain, rows 0-3 only.
//  T4 tile last: push 8 rows back-to-back at 1 row / 8 clk, out_ready=1
//     -> 64 contiguous words; out_last=1 only on word 63.
//     -> row_cnt wraps; the next tile's last is at its word 63.
//  T5 push+pop same cycle at full: FIFO full, pop completes while row_valid=1
//     -> row not accepted that cycle and overflow set.
//     -> The row is accepted the next cycle if re-offered (row_ready=1).
//  T6 async reset mid-row: assert rst after 3 words sent
//     -> out_valid=0 immediately, count=0, overflow=0.
//     -> After release, a new row streams starting at column 0.

Source files
------------

// File: rtl/pe_result_drain.sv
// Buffers rows of N 32-bit PE results in a DEPTH-row FIFO and streams each row
// out word by word (column 0 first). out_last marks the final word of each ROWS-row tile.
module pe_result_drain #(
  parameter int N     = 8,
  parameter int DEPTH = 4,
  parameter int ROWS  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            row_valid,
  output logic            row_ready,
  input  logic [32*N-1:0] row_data,
  output logic [31:0]     out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic            overflow,
  output logic            busy,
  output logic            dbg_state
);

  // Handshakes: a row transfers on any posedge where row_valid && row_ready;
  // a word transfers on any posedge where out_valid && out_ready. The producer
  // holds out_data/out_last/out_valid stable while out_valid && !out_ready.

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(N);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [CW-1:0] COL_LAST = CW'(N-1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS-1);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [32*N-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic [CW-1:0]   col_idx;
  logic [RW-1:0]   row_cnt;
  logic [32*N-1:0] head;
  logic [31:0]     head_word;
  logic            push, hs, pop;

  assign row_ready = (count != CNT_FULL);
  assign push      = row_valid && row_ready;
  assign hs        = out_valid && out_ready;
  assign pop       = hs && (col_idx == COL_LAST);
  assign head      = mem[rd_ptr];

  always_comb begin
    head_word = '0;
    for (int c = 0; c < N; c++) begin
      if (CW'(c) == col_idx) head_word = head[c*32 +: 32];
    end
  end

  // Storage carries no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= row_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      col_idx  <= '0;
      row_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (hs) col_idx <= (col_idx == COL_LAST) ? '0 : col_idx + CW'(1);
      if (pop) row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + RW'(1);
      if (row_valid && !row_ready) overflow <= 1'b1;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (push) state_nxt = STREAM;
      STREAM:  if (pop && (count == CNT_ONE) && !push) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy      = (state == STREAM);
    dbg_state = state;
    out_valid = (count != '0);
    out_last  = out_valid && (col_idx == COL_LAST) && (row_cnt == ROW_LAST);
    out_data  = out_valid ? head_word : '0;
  end

endmodule

// File: tb/tb_pe_result_drain.sv
// Directed bench for pe_result_drain: per-cycle vector table for single-row and
// backpressure streaming, plus hand sequences for full, tile-last and reset cases.
module tb_pe_result_drain;

  localparam int N = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            row_valid;
  logic            row_ready;
  logic [32*N-1:0] row_data;
  logic [31:0]     out_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;
  logic            overflow;
  logic            busy;
  logic            dbg_state;

  pe_result_drain #(.N(N), .DEPTH(4), .ROWS(8)) dut (
    .clk(clk), .rst(rst),
    .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .overflow(overflow), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic [31:0] base;
    logic        ordy;
    logic        ev;
    logic [31:0] ed;
    logic        el;
    logic        eb;
    logic        erdy;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          m_col  = 0;
  int          m_row  = 0;
  int          bubbles;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [32*N-1:0] make_row(input logic [31:0] base);
    logic [32*N-1:0] r;
    for (int c = 0; c < N; c++) r[c*32 +: 32] = base + 32'(c);
    return r;
  endfunction

  task automatic enqueue_row(input logic [31:0] base);
    for (int c = 0; c < N; c++) exp_q.push_back(base + 32'(c));
  endtask

  function automatic vec_t mk(input logic rv, input logic [31:0] base, input logic ordy,
                              input logic ev, input logic [31:0] ed, input logic el,
                              input logic eb, input logic erdy);
    vec_t v;
    v.rv = rv; v.base = base; v.ordy = ordy; v.ev = ev;
    v.ed = ed; v.el = el; v.eb = eb; v.erdy = erdy;
    return v;
  endfunction

  // Reference position of the next word within its row and tile.
  task automatic model_advance();
    if (m_col == N-1) begin
      m_col = 0;
      m_row = (m_row == 7) ? 0 : m_row + 1;
    end else begin
      m_col++;
    end
  endtask

  task automatic check_word();
    logic [31:0] exp_w;
    if (exp_q.size() == 0) begin
      chk("extra_word", 32'(out_valid), 32'(0));
    end else begin
      exp_w = exp_q.pop_front();
      chk("word", out_data, exp_w);
    end
    chk("word_last", 32'(out_last), 32'((m_col == N-1) && (m_row == 7)));
    model_advance();
  endtask

  // Starts and ends just after a posedge; collects up to n_words handshakes.
  task automatic drain(input int max_cycles, input int n_words, output int gaps);
    int got = 0;
    gaps = 0;
    for (int c = 0; c < max_cycles && got < n_words; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        check_word();
        got++;
      end else if (got > 0) begin
        gaps++;
      end
      tick();
    end
    chk("drain_count", 32'(got), 32'(n_words));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    exp_q.delete();
    m_col = 0;
    m_row = 0;
  endtask

  initial begin
    rst = 1'b1; row_valid = 1'b0; row_data = '0; out_ready = 1'b0;

    // T1: single row, out_ready held high
    vecs.push_back(mk(1, 32'h100, 1, 0, 0, 0, 0, 1));
    for (int i = 0; i < N; i++) vecs.push_back(mk(0, 0, 1, 1, 32'h100 + 32'(i), 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1));
    // T2: ready high one cycle in three; word k is visible cycles 3k-1..3k+1
    vecs.push_back(mk(1, 32'h100, 0, 0, 0, 0, 0, 1));
    for (int c = 1; c <= 22; c++)
      vecs.push_back(mk(0, 0, (c % 3) == 1, 1, 32'h100 + 32'((c + 1) / 3), 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_last",  32'(out_last), 0);
    chk("rst_busy",      32'(busy), 0);
    chk("rst_overflow",  32'(overflow), 0);
    chk("rst_out_data",  out_data, 0);
    chk("rst_row_ready", 32'(row_ready), 1);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      row_valid = vecs[i].rv;
      row_data  = make_row(vecs[i].base);
      out_ready = vecs[i].ordy;
      @(negedge clk);
      chk("tbl_valid", 32'(out_valid), 32'(vecs[i].ev));
      chk("tbl_busy",  32'(busy), 32'(vecs[i].eb));
      chk("tbl_last",  32'(out_last), 32'(vecs[i].el));
      chk("tbl_ready", 32'(row_ready), 32'(vecs[i].erdy));
      if (vecs[i].ev) chk("tbl_data", out_data, vecs[i].ed);
      tick();
    end
    row_valid = 1'b0;
    m_row = 2;  // two complete rows streamed by the table

    // T3: fill with out_ready low, fifth row overflows
    out_ready = 1'b0;
    for (int r = 0; r < 5; r++) begin
      row_valid = 1'b1;
      row_data  = make_row(32'h200 + 32'(r) * 32'h100);
      @(negedge clk);
      chk("t3_row_ready", 32'(row_ready), 32'(r < 4));
      if (r < 4) enqueue_row(32'h200 + 32'(r) * 32'h100);
      tick();
    end
    row_valid = 1'b0;
    @(negedge clk);
    chk("t3_overflow",  32'(overflow), 1);
    chk("t3_full",      32'(row_ready), 0);
    chk("t3_head_held", out_data, 32'h200);
    tick();
    out_ready = 1'b1;
    drain(100, 32, bubbles);
    @(negedge clk);
    chk("t3_q_empty", 32'(exp_q.size()), 0);
    chk("t3_idle",    32'(out_valid), 0);
    chk("t3_busy",    32'(busy), 0);
    tick();

    // T6: async reset after three words of a row
    row_valid = 1'b1;
    row_data  = make_row(32'h700);
    enqueue_row(32'h700);
    tick();
    row_valid = 1'b0;
    drain(10, 3, bubbles);
    #2 rst = 1'b1;
    #1;
    chk("t6_valid_drop", 32'(out_valid), 0);
    chk("t6_busy",       32'(busy), 0);
    chk("t6_overflow",   32'(overflow), 0);
    chk("t6_row_ready",  32'(row_ready), 1);
    chk("t6_last",       32'(out_last), 0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    m_col = 0;
    m_row = 0;
    row_valid = 1'b1;
    row_data  = make_row(32'h800);
    enqueue_row(32'h800);
    tick();
    row_valid = 1'b0;
    drain(20, 8, bubbles);
    @(negedge clk);
    chk("t6_busy_end", 32'(busy), 0);
    tick();

    // T5: final-column pop while full does not admit a same-cycle push
    out_ready = 1'b0;
    for (int r = 0; r < 4; r++) begin
      row_valid = 1'b1;
      row_data  = make_row(32'h900 + 32'(r) * 32'h10);
      enqueue_row(32'h900 + 32'(r) * 32'h10);
      tick();
    end
    row_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (i == N-1) begin
        row_valid = 1'b1;
        row_data  = make_row(32'hA00);
      end
      @(negedge clk);
      if (i == N-1) begin
        chk("t5_full_at_pop", 32'(row_ready), 0);
        chk("t5_no_ovf_yet",  32'(overflow), 0);
      end
      check_word();
      tick();
    end
    out_ready = 1'b0;
    @(negedge clk);
    chk("t5_overflow",  32'(overflow), 1);
    chk("t5_row_ready", 32'(row_ready), 1);
    enqueue_row(32'hA00);
    tick();
    row_valid = 1'b0;
    @(negedge clk);
    chk("t5_full_again", 32'(row_ready), 0);
    tick();
    out_ready = 1'b1;
    drain(100, 32, bubbles);
    chk("t5_q_empty", 32'(exp_q.size()), 0);

    // T4: two tiles at one row per N clocks; out_last only on word 63 of each
    do_reset();
    out_ready = 1'b1;
    fork
      begin
        for (int r = 0; r < 16; r++) begin
          row_valid = 1'b1;
          row_data  = make_row(32'h1000 + 32'(r) * 32'h10);
          enqueue_row(32'h1000 + 32'(r) * 32'h10);
          tick();
          row_valid = 1'b0;
          repeat (N-1) tick();
        end
      end
      drain(200, 128, bubbles);
    join
    chk("t4_contiguous", 32'(bubbles), 0);
    chk("t4_q_empty",    32'(exp_q.size()), 0);
    @(negedge clk);
    chk("t4_busy_end", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
